// File: rtl/dispense_pkg.sv
// Shared types and helpers for the PWM dispense arbiter: FSM state encoding,
// default sizing constants and the round-robin winner search.
package dispense_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_GUARD = 2'd2
    } state_e;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DUTY_W = 8;
    localparam int MAX_CH     = 8;
    localparam int PTR_W      = 3;

    // First requester at or after ptr, wrapping modulo n (n <= MAX_CH, ptr < n).
    function automatic logic [PTR_W-1:0] rr_pick(
        input logic [MAX_CH-1:0] req,
        input logic [PTR_W-1:0]  ptr,
        input int                n
    );
        logic [PTR_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_CH; i++) begin
            idx = int'(ptr) + i;
            if (idx >= n) idx = idx - n;
            if ((i < n) && !found && req[PTR_W'(idx)]) begin
                pick  = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/pwm_core.sv
// PWM counter pair for one dispense grant: tick counter, period counter,
// latched duty compare and end-of-run detection.
module pwm_core #(
    parameter int DUTY_W      = 8,
    parameter int RUN_PERIODS = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              pwm_tick,
    input  logic [DUTY_W-1:0] duty,
    output logic              pwm_o,
    output logic              last_tick
);

    localparam int PER_W = (RUN_PERIODS > 1) ? $clog2(RUN_PERIODS) : 1;

    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic [PER_W-1:0]  per_q, per_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              pwm_q, pwm_d;
    logic              cnt_wrap;

    assign cnt_wrap  = &cnt_q;
    assign last_tick = en && pwm_tick && cnt_wrap && (per_q == PER_W'(RUN_PERIODS - 1));

    // pwm_q always equals (en && cnt_q < duty_q) for the state being entered,
    // so the registered output lines up with the counter it describes.
    always_comb begin
        cnt_d  = cnt_q;
        per_d  = per_q;
        duty_d = duty_q;
        pwm_d  = 1'b0;
        if (clr) begin
            cnt_d  = '0;
            per_d  = '0;
            duty_d = duty;
            pwm_d  = (duty != '0);
        end else if (en) begin
            if (pwm_tick) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_wrap) per_d = per_q + 1'b1;
            end
            pwm_d = !last_tick && (cnt_d < duty_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            per_q  <= '0;
            duty_q <= '0;
            pwm_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            per_q  <= per_d;
            duty_q <= duty_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_dispense_arbiter.sv
// Round-robin arbiter time-sharing one PWM generator across dispense channels.
// Optional post-run dead time is enabled by defining PWM_DISPENSE_GUARD_EN.
module pwm_dispense_arbiter
    import dispense_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DUTY_W      = DEF_DUTY_W,
    parameter int RUN_PERIODS = 64
`ifdef PWM_DISPENSE_GUARD_EN
    ,
    parameter int GUARD_TICKS = 512
`endif
) (
    input  logic                       clock_test,
    input  logic                       rst,
    input  logic                       pwm_tick,
    input  logic [NUM_CH-1:0]          req,
    input  logic [NUM_CH*DUTY_W-1:0]   duty_cfg,
    output logic [NUM_CH-1:0]          grant,
    output logic [$clog2(NUM_CH)-1:0]  pwm_sel,
    output logic                       pwm_o,
    output logic [NUM_CH-1:0]          done,
    output logic                       busy
);

    localparam int SEL_W = $clog2(NUM_CH);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [NUM_CH-1:0]  grant_q, grant_d;
    logic [NUM_CH-1:0]  done_q, done_d;
    logic               busy_q, busy_d;
    logic               core_en, core_clr, last_tick;
    logic [SEL_W-1:0]   winner;
    logic [DUTY_W-1:0]  duty_arr [NUM_CH];

`ifdef PWM_DISPENSE_GUARD_EN
    localparam int GW = $clog2(GUARD_TICKS + 1);
    logic [GW-1:0] guard_q, guard_d;
`endif

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_duty
        assign duty_arr[gi] = duty_cfg[gi*DUTY_W +: DUTY_W];
    end

    assign winner = SEL_W'(rr_pick(MAX_CH'(req), PTR_W'(rr_ptr_q), NUM_CH));

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        sel_d    = sel_q;
        grant_d  = grant_q;
        done_d   = '0;
        busy_d   = busy_q;
        core_clr = 1'b0;
        core_en  = (state_q == ST_RUN);
`ifdef PWM_DISPENSE_GUARD_EN
        guard_d  = guard_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    core_clr = 1'b1;
                    grant_d  = NUM_CH'(1) << winner;
                    sel_d    = winner;
                    busy_d   = 1'b1;
                    rr_ptr_d = (int'(winner) == NUM_CH - 1) ? '0 : winner + SEL_W'(1);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_tick) begin
                    done_d  = grant_q;
                    grant_d = '0;
                    sel_d   = '0;
`ifdef PWM_DISPENSE_GUARD_EN
                    guard_d = '0;
                    state_d = ST_GUARD;
`else
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef PWM_DISPENSE_GUARD_EN
            ST_GUARD: begin
                if (pwm_tick) begin
                    if (guard_q == GW'(GUARD_TICKS - 1)) begin
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        guard_d = guard_q + 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_test) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            sel_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
`ifdef PWM_DISPENSE_GUARD_EN
            guard_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            sel_q    <= sel_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
`ifdef PWM_DISPENSE_GUARD_EN
            guard_q  <= guard_d;
`endif
        end
    end

    pwm_core #(
        .DUTY_W      (DUTY_W),
        .RUN_PERIODS (RUN_PERIODS)
    ) u_core (
        .clk       (clock_test),
        .rst       (rst),
        .en        (core_en),
        .clr       (core_clr),
        .pwm_tick  (pwm_tick),
        .duty      (duty_arr[winner]),
        .pwm_o     (pwm_o),
        .last_tick (last_tick)
    );

    assign grant   = grant_q;
    assign pwm_sel = sel_q;
    assign done    = done_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_pwm_dispense_arbiter.sv
// Bench for pwm_dispense_arbiter: random pwm_tick stimulus checked every cycle
// against a tick-counting reference model, plus per-scenario checks.
module tb_pwm_dispense_arbiter;

    localparam int NUM_CH      = 4;
    localparam int DUTY_W      = 8;
    localparam int RUN_PERIODS = 2;
    localparam int GUARD_TICKS = 10;
    localparam int PERIOD      = 1 << DUTY_W;
    localparam int RUN_TICKS   = RUN_PERIODS * PERIOD;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic                     pwm_tick;
    logic [NUM_CH-1:0]        req;
    logic [NUM_CH*DUTY_W-1:0] duty_cfg;
    logic [NUM_CH-1:0]        grant;
    logic [1:0]               pwm_sel;
    logic                     pwm_o;
    logic [NUM_CH-1:0]        done;
    logic                     busy;

    int n_vec = 0;
    int n_err = 0;
    int tick_pct = 50;

    // reference model: mode 0 idle, 1 run, 2 guard
    int           m_mode, m_owner, m_ticks, m_duty, m_rr, m_gticks;
    logic [3:0]   m_done;
    logic [11:0]  exp_vec;

    pwm_dispense_arbiter #(
        .NUM_CH      (NUM_CH),
        .DUTY_W      (DUTY_W),
        .RUN_PERIODS (RUN_PERIODS)
`ifdef PWM_DISPENSE_GUARD_EN
        ,
        .GUARD_TICKS (GUARD_TICKS)
`endif
    ) dut (
        .clock_test (clk),
        .rst        (rst),
        .pwm_tick   (pwm_tick),
        .req        (req),
        .duty_cfg   (duty_cfg),
        .grant      (grant),
        .pwm_sel    (pwm_sel),
        .pwm_o      (pwm_o),
        .done       (done),
        .busy       (busy)
    );

    function automatic logic [11:0] obs_vec();
        return {grant, pwm_sel, pwm_o, done, busy};
    endfunction

    task automatic model_step();
        m_done = '0;
        if (rst) begin
            m_mode = 0; m_owner = 0; m_ticks = 0; m_duty = 0; m_rr = 0; m_gticks = 0;
        end else begin
            case (m_mode)
                0: if (req != 0) begin
                    int w;
                    w = -1;
                    for (int k = 0; k < NUM_CH; k++)
                        if (w < 0 && req[(m_rr + k) % NUM_CH]) w = (m_rr + k) % NUM_CH;
                    m_owner = w;
                    m_duty  = int'(duty_cfg[w*DUTY_W +: DUTY_W]);
                    m_ticks = 0;
                    m_rr    = (w + 1) % NUM_CH;
                    m_mode  = 1;
                end
                1: if (pwm_tick) begin
                    m_ticks++;
                    if (m_ticks == RUN_TICKS) begin
                        m_done[m_owner] = 1'b1;
`ifdef PWM_DISPENSE_GUARD_EN
                        m_mode = 2; m_gticks = 0;
`else
                        m_mode = 0;
`endif
                    end
                end
                default: if (pwm_tick) begin
                    m_gticks++;
                    if (m_gticks == GUARD_TICKS) m_mode = 0;
                end
            endcase
        end
        exp_vec = {(m_mode == 1) ? 4'(1 << m_owner) : 4'b0,
                   (m_mode == 1) ? 2'(m_owner) : 2'b0,
                   (m_mode == 1) && ((m_ticks % PERIOD) < m_duty),
                   m_done,
                   m_mode != 0};
    endtask

    task automatic drive_cycle();
        model_step();
        @(posedge clk);
        #1;
        pwm_tick = ($urandom_range(99, 0) < tick_pct);
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; duty_cfg = '0; pwm_tick = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_cycle();
            n_vec++;
            if (obs_vec() !== exp_vec) begin
                n_err++; $display("FAIL reset_model: got %h want %h", obs_vec(), exp_vec);
            end
        end
        n_vec++;
        if (obs_vec() !== 12'h000) begin
            n_err++; $display("FAIL reset_values: got %h want 000", obs_vec());
        end
        rst = 1'b0;
        $display("txn reset outputs=%h", obs_vec());
    endtask

    task automatic test_single();
        int ticks, highs; bit got; logic [3:0] d;
        ticks = 0; highs = 0; got = 0; d = '0;
        tick_pct = 60;
        duty_cfg[7:0] = 8'd128; req = 4'b0001;
        drive_cycle();
        n_vec++;
        if (grant !== 4'b0001 || busy !== 1'b1) begin
            n_err++; $display("FAIL single_latency: grant %b busy %b want 0001 1", grant, busy);
        end
        for (int c = 0; c < 4000 && !got; c++) begin
            if (grant != 0 && pwm_tick) begin ticks++; highs += int'(pwm_o); end
            drive_cycle();
            n_vec++;
            if (obs_vec() !== exp_vec) begin
                n_err++; $display("FAIL single_model: got %h want %h", obs_vec(), exp_vec);
            end
            if (done != 0) begin got = 1; d = done; end
        end
        req = '0;
        n_vec++;
        if (!got || ticks != RUN_TICKS || highs != 256 || d !== 4'b0001) begin
            n_err++;
            $display("FAIL single_run: done %b ticks %0d high %0d want 0001 512 256", d, ticks, highs);
        end
        $display("txn single ch0 ticks=%0d high=%0d done=%b", ticks, highs, d);
    endtask

    task automatic test_round_robin();
        int order[$]; int ndone; logic [3:0] pre_grant;
        int exp_order[5] = '{0, 1, 2, 3, 0};
        ndone = 0;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) drive_cycle();
        rst = 1'b0;
        tick_pct = 100;
        duty_cfg = $urandom;
        req = 4'b1111;
        for (int c = 0; c < 3000 && ndone < 5; c++) begin
            pre_grant = grant;
            drive_cycle();
            n_vec++;
            if (obs_vec() !== exp_vec) begin
                n_err++; $display("FAIL rr_model: got %h want %h", obs_vec(), exp_vec);
            end
            if (pre_grant == 0 && grant != 0)
                for (int k = 0; k < NUM_CH; k++) if (grant[k]) order.push_back(k);
            if (done != 0) begin
                ndone++;
                if (ndone == 5) req = '0;
                n_vec++;
                if (done !== pre_grant) begin
                    n_err++; $display("FAIL rr_done_owner: done %b owner %b", done, pre_grant);
                end
                $display("txn rr done=%b", done);
            end
        end
        n_vec++;
        if (order.size() != 5) begin
            n_err++; $display("FAIL rr_count: grants %0d want 5", order.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_vec++;
                if (order[k] != exp_order[k]) begin
                    n_err++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], exp_order[k]);
                end
            end
        end
    endtask

    task automatic test_duty_edges();
        int chs[2] = '{2, 3};
        int want_high[2] = '{0, 2 * (PERIOD - 1)};
        tick_pct = 70;
        duty_cfg[2*DUTY_W +: DUTY_W] = 8'd0;
        duty_cfg[3*DUTY_W +: DUTY_W] = 8'd255;
        for (int e = 0; e < 2; e++) begin
            int ticks, highs; bit got;
            ticks = 0; highs = 0; got = 0;
            req = 4'(1 << chs[e]);
            for (int c = 0; c < 4000 && !got; c++) begin
                if (grant != 0 && pwm_tick) begin ticks++; highs += int'(pwm_o); end
                drive_cycle();
                n_vec++;
                if (obs_vec() !== exp_vec) begin
                    n_err++; $display("FAIL duty_model: got %h want %h", obs_vec(), exp_vec);
                end
                if (done != 0) got = 1;
            end
            req = '0;
            n_vec++;
            if (!got || ticks != RUN_TICKS || highs != want_high[e]) begin
                n_err++;
                $display("FAIL duty_edge ch%0d: ticks %0d high %0d want 512 %0d", chs[e], ticks, highs, want_high[e]);
            end
            $display("txn duty ch%0d ticks=%0d high=%0d", chs[e], ticks, highs);
            for (int c = 0; c < 5; c++) drive_cycle();
        end
    endtask

    task automatic test_mid_run_changes();
        int ticks, highs; bit got; logic [3:0] d;
        ticks = 0; highs = 0; got = 0; d = '0;
        tick_pct = 80;
        duty_cfg[1*DUTY_W +: DUTY_W] = 8'd64;
        req = 4'b0010;
        for (int c = 0; c < 4000 && !got; c++) begin
            if (c == 100) begin
                req = '0;
                duty_cfg = $urandom;
                duty_cfg[1*DUTY_W +: DUTY_W] = 8'd200;
            end
            if (grant != 0 && pwm_tick) begin ticks++; highs += int'(pwm_o); end
            drive_cycle();
            n_vec++;
            if (obs_vec() !== exp_vec) begin
                n_err++; $display("FAIL midrun_model: got %h want %h", obs_vec(), exp_vec);
            end
            if (done != 0) begin got = 1; d = done; end
        end
        n_vec++;
        if (!got || ticks != RUN_TICKS || highs != 128 || d !== 4'b0010) begin
            n_err++;
            $display("FAIL midrun: done %b ticks %0d high %0d want 0010 512 128", d, ticks, highs);
        end
        $display("txn midrun ch1 ticks=%0d high=%0d done=%b", ticks, highs, d);
        for (int c = 0; c < 5; c++) drive_cycle();
    endtask

    task automatic test_reset_mid_run();
        int saw_done; bit got;
        saw_done = 0; got = 0;
        tick_pct = 90;
        duty_cfg = $urandom;
        req = 4'b0010;
        for (int c = 0; c < 150; c++) begin
            drive_cycle();
            n_vec++;
            if (obs_vec() !== exp_vec) begin
                n_err++; $display("FAIL rstrun_model: got %h want %h", obs_vec(), exp_vec);
            end
        end
        rst = 1'b1;
        drive_cycle();
        rst = 1'b0; req = '0;
        n_vec++;
        if (obs_vec() !== 12'h000) begin
            n_err++; $display("FAIL rstrun_outputs: got %h want 000", obs_vec());
        end
        for (int c = 0; c < 20; c++) begin
            drive_cycle();
            if (done != 0) saw_done++;
        end
        n_vec++;
        if (saw_done != 0) begin
            n_err++; $display("FAIL rstrun_no_done: pulses %0d want 0", saw_done);
        end
        req = 4'b1111;
        drive_cycle();
        req = '0;
        n_vec++;
        if (grant !== 4'b0001 || pwm_sel !== 2'd0) begin
            n_err++; $display("FAIL rstrun_restart: grant %b sel %0d want 0001 0", grant, pwm_sel);
        end
        for (int c = 0; c < 4000 && !got; c++) begin
            drive_cycle();
            n_vec++;
            if (obs_vec() !== exp_vec) begin
                n_err++; $display("FAIL rstrun_model2: got %h want %h", obs_vec(), exp_vec);
            end
            if (done != 0) got = 1;
        end
        n_vec++;
        if (!got) begin
            n_err++; $display("FAIL rstrun_timeout: done %b want pulse", done);
        end
        $display("txn reset_mid_run restart grant ch0 completed=%0d", got);
        for (int c = 0; c < 5; c++) drive_cycle();
    endtask

`ifdef PWM_DISPENSE_GUARD_EN
    task automatic test_guard();
        int gticks, phase;
        gticks = 0; phase = 0;
        tick_pct = 50;
        req = 4'b0001;
        for (int c = 0; c < 5000 && phase < 2; c++) begin
            if (phase == 1 && busy && grant == 0 && pwm_tick) gticks++;
            drive_cycle();
            n_vec++;
            if (obs_vec() !== exp_vec) begin
                n_err++; $display("FAIL guard_model: got %h want %h", obs_vec(), exp_vec);
            end
            if (phase == 0 && done != 0) phase = 1;
            else if (phase == 1 && grant != 0) phase = 2;
        end
        req = '0;
        n_vec++;
        if (phase != 2 || gticks != GUARD_TICKS) begin
            n_err++; $display("FAIL guard_ticks: got %0d want %0d (phase %0d)", gticks, GUARD_TICKS, phase);
        end
        $display("txn guard ticks=%0d", gticks);
        for (int c = 0; c < 1500; c++) drive_cycle();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_duty_edges();
        test_mid_run_changes();
        test_reset_mid_run();
`ifdef PWM_DISPENSE_GUARD_EN
        test_guard();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
